// File: rtl/div_sqrt_issue_queue_pkg.sv
// Shared constants for the divide/sqrt issue queue: FSM state encodings and
// the widths of the fixed request/response fields.
package div_sqrt_issue_queue_pkg;

  typedef logic [1:0] state_t;

  localparam state_t ST_IDLE = 2'd0;
  localparam state_t ST_WAIT = 2'd1;
  localparam state_t ST_HOLD = 2'd2;

  localparam int SQRT_WIDTH  = 1;
  localparam int ROUND_WIDTH = 3;
  localparam int FLAG_WIDTH  = 5;

  // Packed request entry is {sqrtOp, a, b, roundingMode, tag}.
  function automatic int entryWidth(input int expW, input int sigW, input int tagW);
    return SQRT_WIDTH + 2 * (expW + sigW + 1) + ROUND_WIDTH + tagW;
  endfunction

endpackage

// File: rtl/div_sqrt_req_fifo.sv
// Request FIFO with wrap-bit pointers; only the pointers are reset, the
// storage array is left uninitialised.
module div_sqrt_req_fifo #(
  parameter int dataWidth = 8,
  parameter int depth     = 4
) (
  input  logic                 clock,
  input  logic                 reset,
  input  logic                 push,
  input  logic                 pop,
  input  logic [dataWidth-1:0] wdata,
  output logic [dataWidth-1:0] rdata,
  output logic                 empty,
  output logic                 full
);

  localparam int addrWidth = $clog2(depth);

  logic [addrWidth:0]   wptr;
  logic [addrWidth:0]   rptr;
  logic [dataWidth-1:0] mem [depth];

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      wptr <= '0;
      rptr <= '0;
    end else begin
      if (push && !full) wptr <= wptr + 1'b1;
      if (pop && !empty) rptr <= rptr + 1'b1;
    end
  end

  always_ff @(posedge clock) begin
    if (push && !full) mem[wptr[addrWidth-1:0]] <= wdata;
  end

  // Equal low bits with differing wrap bits means the writer lapped the reader.
  assign empty = (wptr == rptr);
  assign full  = (wptr[addrWidth] != rptr[addrWidth]) &&
                 (wptr[addrWidth-1:0] == rptr[addrWidth-1:0]);
  assign rdata = mem[rptr[addrWidth-1:0]];

endmodule

// File: rtl/div_sqrt_issue_queue.sv
// Buffers divide/sqrt requests and feeds them one at a time to a divider
// without result backpressure, holding each result until downstream takes it.
module div_sqrt_issue_queue
  import div_sqrt_issue_queue_pkg::*;
#(
  parameter int expWidth = 8,
  parameter int sigWidth = 24,
  parameter int depth    = 4,
  parameter int tagWidth = 4
) (
  input  logic                            clock,
  input  logic                            reset,
  input  logic                            req_valid,
  output logic                            req_ready,
  input  logic                            req_sqrtOp,
  input  logic [expWidth+sigWidth:0]      req_a,
  input  logic [expWidth+sigWidth:0]      req_b,
  input  logic [ROUND_WIDTH-1:0]          req_roundingMode,
  input  logic [tagWidth-1:0]             req_tag,
  input  logic                            ds_inReady,
  output logic                            ds_inValid,
  output logic                            ds_sqrtOp,
  output logic [expWidth+sigWidth:0]      ds_a,
  output logic [expWidth+sigWidth:0]      ds_b,
  output logic [ROUND_WIDTH-1:0]          ds_roundingMode,
  input  logic                            ds_outValid,
  input  logic [expWidth+sigWidth:0]      ds_out,
  input  logic [FLAG_WIDTH-1:0]           ds_exceptionFlags,
  output logic                            resp_valid,
  input  logic                            resp_ready,
  output logic [tagWidth-1:0]             resp_tag,
  output logic                            resp_sqrtOp,
  output logic [expWidth+sigWidth:0]      resp_out,
  output logic [FLAG_WIDTH-1:0]           resp_exceptionFlags,
  output logic                            busy,
  output logic                            protocol_err
);

  localparam int entryW = entryWidth(expWidth, sigWidth, tagWidth);

  state_t              state;
  state_t              stateNext;
  logic                empty;
  logic                full;
  logic                push;
  logic                issue;
  logic [entryW-1:0]   headEntry;
  logic [tagWidth-1:0] headTag;
  logic [tagWidth-1:0] flightTag;
  logic                flightSqrt;

  assign push  = req_valid && !full;
  assign issue = ds_inValid && ds_inReady;

  div_sqrt_req_fifo #(
    .dataWidth(entryW),
    .depth    (depth)
  ) u_fifo (
    .clock(clock),
    .reset(reset),
    .push (push),
    .pop  (issue),
    .wdata({req_sqrtOp, req_a, req_b, req_roundingMode, req_tag}),
    .rdata(headEntry),
    .empty(empty),
    .full (full)
  );

  assign {ds_sqrtOp, ds_a, ds_b, ds_roundingMode, headTag} = headEntry;

  // A new issue is allowed only when nothing is in the divider and the held
  // result is leaving this cycle, so at most one operation is ever outstanding.
  assign ds_inValid = !empty && ((state == ST_IDLE) || ((state == ST_HOLD) && resp_ready));
  assign req_ready  = !full;
  assign resp_valid = (state == ST_HOLD);
  assign busy       = !empty || (state != ST_IDLE);

  always_comb begin
    stateNext = state;
    case (state)
      ST_IDLE: if (issue) stateNext = ST_WAIT;
      ST_WAIT: if (ds_outValid) stateNext = ST_HOLD;
      ST_HOLD: if (resp_ready) stateNext = issue ? ST_WAIT : ST_IDLE;
      default: stateNext = ST_IDLE;
    endcase
  end

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      state        <= ST_IDLE;
      protocol_err <= 1'b0;
    end else begin
      state <= stateNext;
      if (ds_outValid && (state != ST_WAIT)) protocol_err <= 1'b1;
    end
  end

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      flightTag           <= '0;
      flightSqrt          <= 1'b0;
      resp_tag            <= '0;
      resp_sqrtOp         <= 1'b0;
      resp_out            <= '0;
      resp_exceptionFlags <= '0;
    end else begin
      if (issue) begin
        flightTag  <= headTag;
        flightSqrt <= ds_sqrtOp;
      end
      if ((state == ST_WAIT) && ds_outValid) begin
        resp_tag            <= flightTag;
        resp_sqrtOp         <= flightSqrt;
        resp_out            <= ds_out;
        resp_exceptionFlags <= ds_exceptionFlags;
      end
    end
  end

endmodule

// File: tb/tb_div_sqrt_issue_queue.sv
// Directed and randomized bench for div_sqrt_issue_queue, checked against a
// queue-based transaction model of the request/response behaviour.
module tb_div_sqrt_issue_queue;

  localparam int W     = 33;
  localparam int DEPTH = 4;
  localparam int TAGW  = 4;
  localparam logic [W-1:0] ONE_REC = 33'h0_8000_0000;

  typedef struct packed {
    logic            sqrt;
    logic [W-1:0]    a;
    logic [W-1:0]    b;
    logic [2:0]      rm;
    logic [TAGW-1:0] tag;
  } req_t;

  typedef struct packed {
    logic [TAGW-1:0] tag;
    logic            sqrt;
    logic [W-1:0]    out;
    logic [4:0]      flags;
  } resp_t;

  logic            clock = 1'b0;
  logic            reset = 1'b0;
  logic            req_valid = 1'b0;
  logic            req_ready;
  logic            req_sqrtOp = 1'b0;
  logic [W-1:0]    req_a = '0;
  logic [W-1:0]    req_b = '0;
  logic [2:0]      req_roundingMode = '0;
  logic [TAGW-1:0] req_tag = '0;
  logic            ds_inReady = 1'b0;
  logic            ds_inValid;
  logic            ds_sqrtOp;
  logic [W-1:0]    ds_a;
  logic [W-1:0]    ds_b;
  logic [2:0]      ds_roundingMode;
  logic            ds_outValid = 1'b0;
  logic [W-1:0]    ds_out = '0;
  logic [4:0]      ds_exceptionFlags = '0;
  logic            resp_valid;
  logic            resp_ready = 1'b0;
  logic [TAGW-1:0] resp_tag;
  logic            resp_sqrtOp;
  logic [W-1:0]    resp_out;
  logic [4:0]      resp_exceptionFlags;
  logic            busy;
  logic            protocol_err;

  int errors = 0;
  int checks = 0;

  // Transaction model: pending requests, one in-flight slot, held response.
  req_t  pending[$];
  req_t  inFlight;
  resp_t held;
  bit    divBusy;
  bit    holding;
  bit    errSticky;

  div_sqrt_issue_queue #(
    .expWidth(8), .sigWidth(24), .depth(DEPTH), .tagWidth(TAGW)
  ) dut (
    .clock(clock), .reset(reset),
    .req_valid(req_valid), .req_ready(req_ready), .req_sqrtOp(req_sqrtOp),
    .req_a(req_a), .req_b(req_b), .req_roundingMode(req_roundingMode), .req_tag(req_tag),
    .ds_inReady(ds_inReady), .ds_inValid(ds_inValid), .ds_sqrtOp(ds_sqrtOp),
    .ds_a(ds_a), .ds_b(ds_b), .ds_roundingMode(ds_roundingMode),
    .ds_outValid(ds_outValid), .ds_out(ds_out), .ds_exceptionFlags(ds_exceptionFlags),
    .resp_valid(resp_valid), .resp_ready(resp_ready), .resp_tag(resp_tag),
    .resp_sqrtOp(resp_sqrtOp), .resp_out(resp_out), .resp_exceptionFlags(resp_exceptionFlags),
    .busy(busy), .protocol_err(protocol_err)
  );

  always #5 clock = ~clock;

  task automatic checkVal(input string name, input logic [127:0] observed, input logic [127:0] expected);
    checks++;
    assert (observed === expected) else begin
      errors++;
      $error("[TB] FAIL %s observed=%0h expected=%0h", name, observed, expected);
    end
  endtask

  function automatic bit modelIssueOffered();
    return (pending.size() > 0) && ((!divBusy && !holding) || (holding && resp_ready));
  endfunction

  task automatic checkOutput();
    bit offered;
    offered = modelIssueOffered();
    checkVal("req_ready", req_ready, pending.size() < DEPTH);
    checkVal("ds_inValid", ds_inValid, offered);
    if (offered)
      checkVal("ds_head", {ds_sqrtOp, ds_a, ds_b, ds_roundingMode},
               {pending[0].sqrt, pending[0].a, pending[0].b, pending[0].rm});
    checkVal("resp_valid", resp_valid, holding);
    checkVal("resp_data", {resp_tag, resp_sqrtOp, resp_out, resp_exceptionFlags}, held);
    checkVal("busy", busy, (pending.size() > 0) || divBusy || holding);
    checkVal("protocol_err", protocol_err, errSticky);
  endtask

  task automatic updateModel();
    bit   issue;
    req_t incoming;
    issue = modelIssueOffered() && ds_inReady;
    if (ds_outValid && !divBusy) errSticky = 1'b1;
    if (holding && resp_ready) holding = 1'b0;
    if (divBusy && ds_outValid) begin
      held    = '{tag: inFlight.tag, sqrt: inFlight.sqrt, out: ds_out, flags: ds_exceptionFlags};
      divBusy = 1'b0;
      holding = 1'b1;
    end
    if (issue) begin
      inFlight = pending.pop_front();
      divBusy  = 1'b1;
    end
    if (req_valid && pending.size() + (issue ? 1 : 0) < DEPTH) begin
      incoming = '{sqrt: req_sqrtOp, a: req_a, b: req_b, rm: req_roundingMode, tag: req_tag};
      pending.push_back(incoming);
    end
  endtask

  // One clock: set inputs, let them settle, compare, advance model and DUT.
  task automatic applyStimulus(input bit rv, input bit sq, input int tag, input bit dsReady,
                               input bit outValid, input logic [W-1:0] outVal,
                               input logic [4:0] flags, input bit rReady);
    req_valid         = rv;
    req_sqrtOp        = sq;
    req_tag           = tag[TAGW-1:0];
    req_a             = {$urandom_range(0, 1), $urandom()};
    req_b             = {$urandom_range(0, 1), $urandom()};
    req_roundingMode  = 3'($urandom_range(0, 4));
    ds_inReady        = dsReady;
    ds_outValid       = outValid;
    ds_out            = outVal;
    ds_exceptionFlags = flags;
    resp_ready        = rReady;
    #1;
    checkOutput();
    updateModel();
    @(posedge clock);
    #1;
  endtask

  task automatic idleStep();
    applyStimulus(0, 0, 0, 0, 0, '0, '0, 0);
  endtask

  task automatic doReset();
    req_valid   = 1'b0;
    ds_inReady  = 1'b0;
    ds_outValid = 1'b0;
    resp_ready  = 1'b0;
    reset       = 1'b1;
    pending.delete();
    inFlight  = '0;
    held      = '0;
    divBusy   = 1'b0;
    holding   = 1'b0;
    errSticky = 1'b0;
    #1;
    checkOutput();
    @(posedge clock);
    #1;
    reset = 1'b0;
  endtask

  // Issue the head, then return a result and drain each response in turn.
  task automatic drainAll(input int n);
    applyStimulus(0, 0, 0, 1, 0, '0, '0, 0);
    for (int i = 0; i < n; i++) begin
      applyStimulus(0, 0, 0, 0, 1, {$urandom_range(0, 1), $urandom()}, 5'($urandom_range(0, 31)), 0);
      applyStimulus(0, 0, 0, 1, 0, '0, '0, 1);
    end
  endtask

  initial begin
    doReset();
    checkVal("reset_req_ready", req_ready, 1'b1);
    checkVal("reset_resp_out", resp_out, '0);

    // Single divide with tag 3 and a recoded 1.0 result.
    applyStimulus(1, 0, 3, 0, 0, '0, '0, 0);
    checkVal("issue_next_cycle", ds_inValid, 1'b1);
    applyStimulus(0, 0, 0, 1, 0, '0, '0, 0);
    applyStimulus(0, 0, 0, 0, 1, ONE_REC, 5'd0, 0);
    checkVal("single_resp_valid", resp_valid, 1'b1);
    checkVal("single_resp_tag", resp_tag, 4'd3);
    checkVal("single_resp_out", resp_out, ONE_REC);
    checkVal("single_resp_flags", resp_exceptionFlags, 5'd0);
    applyStimulus(0, 0, 0, 0, 0, '0, '0, 1);
    idleStep();

    // Fill the FIFO, attempt a fifth push, then drain in order.
    for (int t = 0; t < 4; t++) applyStimulus(1, 0, t, 0, 0, '0, '0, 0);
    checkVal("full_req_ready", req_ready, 1'b0);
    applyStimulus(1, 0, 9, 0, 0, '0, '0, 0);
    checkVal("fifth_rejected", pending.size() == DEPTH && pending[DEPTH-1].tag == 4'd3, 1'b1);
    applyStimulus(0, 0, 0, 1, 0, '0, '0, 0);
    for (int t = 0; t < 4; t++) begin
      applyStimulus(0, 0, 0, 0, 1, {$urandom_range(0, 1), $urandom()}, 5'($urandom_range(0, 31)), 0);
      checkVal("drain_order", resp_tag, t[TAGW-1:0]);
      applyStimulus(0, 0, 0, 1, 0, '0, '0, 1);
    end
    idleStep();

    // Hold a result for ten cycles with work queued, then release.
    applyStimulus(1, 0, 10, 0, 0, '0, '0, 0);
    applyStimulus(1, 1, 11, 1, 0, '0, '0, 0);
    applyStimulus(0, 0, 0, 0, 1, {$urandom_range(0, 1), $urandom()}, 5'h11, 0);
    for (int c = 0; c < 10; c++) applyStimulus(0, 0, 0, 1, 0, '0, '0, 0);
    checkVal("hold_tag_stable", resp_tag, 4'd10);
    applyStimulus(0, 0, 0, 1, 0, '0, '0, 1);
    checkVal("release_to_wait_valid", resp_valid, 1'b0);
    checkVal("release_to_wait_busy", busy, 1'b1);
    applyStimulus(0, 0, 0, 0, 1, ONE_REC, 5'd0, 0);
    checkVal("second_tag", resp_tag, 4'd11);
    applyStimulus(0, 0, 0, 0, 0, '0, '0, 1);

    // Stray divider result while idle.
    applyStimulus(0, 0, 0, 0, 1, ONE_REC, 5'h1f, 0);
    checkVal("stray_err", protocol_err, 1'b1);
    checkVal("stray_no_resp", resp_valid, 1'b0);

    // Reset while waiting with two requests queued.
    doReset();
    for (int t = 0; t < 3; t++) applyStimulus(1, 0, t, 0, 0, '0, '0, 0);
    applyStimulus(0, 0, 0, 1, 0, '0, '0, 0);
    doReset();
    checkVal("reset_busy", busy, 1'b0);
    checkVal("reset_ready", req_ready, 1'b1);
    applyStimulus(0, 0, 0, 0, 1, ONE_REC, 5'd0, 0);
    checkVal("late_result_err", protocol_err, 1'b1);

    // Mixed sqrt/divide ordering.
    doReset();
    applyStimulus(1, 1, 5, 0, 0, '0, '0, 0);
    applyStimulus(1, 0, 6, 0, 0, '0, '0, 0);
    applyStimulus(1, 1, 7, 0, 0, '0, '0, 0);
    drainAll(3);
    idleStep();

    // Randomized traffic with a well-behaved divider.
    for (int c = 0; c < 600; c++) begin
      applyStimulus($urandom_range(0, 1), $urandom_range(0, 1), $urandom_range(0, 15),
                    $urandom_range(0, 3) != 0, divBusy && ($urandom_range(0, 2) == 0),
                    {$urandom_range(0, 1), $urandom()}, 5'($urandom_range(0, 31)),
                    $urandom_range(0, 1));
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/div_sqrt_issue_queue.md
DIV_SQRT_ISSUE_QUEUE -- requirements
Module: div_sqrt_issue_queue

Interface
REQ-001 SHALL have parameters: expWidth, default 8, exponent width; sigWidth, default 24, significand width; depth, default 4, request FIFO entries, a power of 2 and at least 2; tagWidth, default 4, request tag width.
REQ-002 SHALL have ports, with W = expWidth+sigWidth+1:
- clock  in  1  sole clock, rising edge.
- reset  in  1  asynchronous, active-high.
- req_valid, req_ready  in/out  1  upstream request handshake.
- req_sqrtOp  in  1  request type.
- req_a, req_b  in  W  recoded operands.
- req_roundingMode  in  3  rounding mode.
- req_tag  in  tagWidth  request identifier.
- ds_inReady  in  1  from divider inReady.
- ds_inValid  out  1  to divider inValid.
- ds_sqrtOp  out  1  to the divider.
- ds_a, ds_b  out  W  to the divider.
- ds_roundingMode  out  3  to the divider.
- ds_outValid  in  1  divider result pulse.
- ds_out  in  W  divider result.
- ds_exceptionFlags  in  5  divider flags.
- resp_valid, resp_ready  out/in  1  downstream response handshake.
- resp_tag  out  tagWidth  response identifier.
- resp_sqrtOp  out  1  response type.
- resp_out  out  W  result.
- resp_exceptionFlags  out  5  flags.
- busy  out  1  FIFO non-empty or FSM not IDLE.
- protocol_err  out  1  sticky error flag.

Function
REQ-003 SHALL buffer requests in a depth-entry FIFO of {sqrtOp, a, b, roundingMode, tag}; push when req_valid && req_ready.
REQ-004 SHALL drive req_ready = !full; no push in the same cycle when full, even if a pop occurs.
REQ-005 SHALL use read/write pointers of log2(depth)+1 bits that wrap modulo 2*depth; empty = pointers equal; full = MSBs differ and the rest equal.
REQ-006 SHALL have FSM states IDLE, WAIT (one operation in the divider) and HOLD (result held for downstream).
REQ-007 SHALL drive ds_inValid = !empty && (state==IDLE || (state==HOLD && resp_ready)); ds_* data SHALL come combinationally from the FIFO head.
REQ-008 SHALL, on ds_inValid && ds_inReady, pop the head, latch its tag and sqrtOp into an in-flight register, and go to WAIT.
REQ-009 In WAIT, ds_outValid SHALL capture ds_out, ds_exceptionFlags and the in-flight tag/sqrtOp into the response register and go to HOLD.
REQ-010 In HOLD, SHALL assert resp_valid with stable data until resp_ready; on resp_ready SHALL go to WAIT if an issue happens that cycle, else to IDLE.
REQ-011 At most one operation SHALL be outstanding, so an unbackpressured divider result is never dropped.
REQ-012 ds_outValid outside WAIT SHALL be ignored and SHALL set protocol_err, which stays set until reset.
REQ-013 Minimum latency: a request accepted in cycle N SHALL see ds_inValid in N+1; the response SHALL be visible the cycle after ds_outValid.
REQ-014 resp_sqrtOp SHALL equal the latched request sqrtOp; ds_sqrtOpOut is not used.

Reset
REQ-015 On reset: pointers=0, state=IDLE, req_ready=1, ds_inValid=0, resp_valid=0, busy=0, protocol_err=0; response data registers=0; FIFO storage not reset.
REQ-016 Reset mid-operation SHALL discard all queued and in-flight requests, and results arriving after reset SHALL flag protocol_err.

Structure
REQ-017 A shared package SHALL hold the FSM state enum and the request-entry field width constants.
REQ-018 The FIFO SHALL be one sub-module, div_sqrt_req_fifo; the FSM and response register are in the top level.

Verification
REQ-019 Single divide, tag 3: ds_inValid in N+1; ds_outValid with out=0x3F800000-recoded, flags 0 -> resp_valid next cycle with tag 3, flags 0.
REQ-020 Push 4 requests with ds_inReady=0 -> req_ready=0 after the 4th; a 5th req_valid is not accepted; order is preserved on drain (tags 0,1,2,3).
REQ-021 resp_ready held 0 for 10 cycles in HOLD -> ds_inValid=0 and resp data stable; release with FIFO non-empty -> issue and return in the same cycle, state WAIT.
REQ-022 ds_outValid pulsed in IDLE -> protocol_err=1 and resp_valid stays 0.
REQ-023 Reset asserted in WAIT with 2 queued -> next cycle busy=0, req_ready=1; a late ds_outValid sets protocol_err.
REQ-024 Mixed sqrtOp 1,0,1 with tags 5,6,7 -> responses return in order with matching resp_sqrtOp.
